ibus_ahb_master: RTL and testbench
==================================

# ibus_ahb_master

Synthesizable responder for the CPU instruction bus (ibus) that turns each ibus read or write into a single AHB-Lite transfer. It replaces the behavioural wait-cycle fetch model, so instruction fetch can run against the same AHB fabric and SRAM slave that the data cache uses. The block holds `ibus_stall` high until the AHB data phase completes, then presents the result for exactly one cycle.

## Interface
- `ADDR_MASK`, default 32'h1FFF_FFFF: AND-mask applied to `ibus_address` to form `AHB_haddr` (kseg0/kseg1 to physical).
- `HPROT_VAL`, default 4'b0010: constant driven on `AHB_hprot` (opcode fetch, privileged).
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `ibus_address`, in, 32: byte address; held stable by the CPU while stalled.
- `ibus_read`, in, 1: read request.
- `ibus_write`, in, 1: write request; `ibus_read` takes priority if both are high.
- `ibus_byteenable`, in, 4: byte lanes for writes.
- `ibus_wrdata`, in, 32: write data.
- `ibus_rddata`, out, 32: read data, registered.
- `ibus_stall`, out, 1: stall; high while a request is outstanding and not yet complete.
- `ibus_error`, out, 1: high in the completion cycle if the slave returned ERROR.
- `AHB_haddr`, out, 32: AHB address.
- `AHB_htrans`, out, 2: AHB transfer type.
- `AHB_hwrite`, out, 1: AHB write flag.
- `AHB_hsize`, out, 3: AHB transfer size.
- `AHB_hburst`, out, 3: constant SINGLE (3'b000).
- `AHB_hprot`, out, 4: equals `HPROT_VAL`.
- `AHB_hwdata`, out, 32: AHB write data.
- `AHB_hrdata`, in, 32: AHB read data.
- `AHB_hready`, in, 1: AHB ready.
- `AHB_hresp`, in, 1: AHB response; 1 = ERROR.

## Operation
- States:
  - IDLE: `htrans` = IDLE. If `req = ibus_read | ibus_write`, latch the address (masked), direction, size and `wrdata`, then go to ADDR.
  - ADDR: `htrans` = NONSEQ (2'b10) with the latched `haddr`, `hwrite` and `hsize`. When `hready` = 1, go to DATA and drive `htrans` back to IDLE.
  - DATA: `hwdata` = latched `wrdata`. When `hready` = 1:
    - on a read, capture `hrdata` into `ibus_rddata`;
    - latch `err = hresp`;
    - go to DONE.
  - DONE: `ibus_stall` = 0 for one cycle and `ibus_error` = `err`. Go to IDLE.
- `ibus_stall = req & (state != DONE)`. The next request can therefore enter ADDR no earlier than 2 cycles after DONE.
- Size and address low bits come from `ibus_byteenable`:
  - Reads are always a word: `hsize` = 3'b010, `haddr[1:0]` = 0.
  - Writes: `byteenable` 1111 gives word; 0011 / 1100 give halfword with `haddr[1:0]` = 00 / 10; a one-hot mask gives byte with `haddr[1:0]` = the lane index.
  - Any other write mask is issued as a word.
- ERROR response:
  - `hresp` = 1 with `hready` = 0 (first error cycle) is waited through.
  - Completion happens on `hready` = 1.
  - A read that ends in ERROR loads `ibus_rddata` with 32'h0.
- Request dropped mid-transaction (`req` falls in ADDR or DATA): the AHB transfer still completes. On completion go straight to IDLE, skipping DONE; `ibus_rddata` is not updated.

## Timing
- Reset values: state IDLE; `ibus_rddata` = 0; `ibus_error` = 0; `AHB_htrans` = 2'b00; `AHB_haddr` = 0; `AHB_hwrite` = 0; `AHB_hsize` = 3'b010; `AHB_hwdata` = 0. `ibus_stall` = `req` during reset.
- All AHB outputs are registered.
- Zero-wait slave: request seen at T0 (IDLE); T1 ADDR; T2 DATA; T3 DONE with `ibus_stall` = 0 and data valid. This is 3 stall cycles.
- Each slave wait state (`hready` = 0) in ADDR or DATA adds one cycle.
- Reset asserted mid-transaction returns to IDLE on the next edge; the outstanding AHB beat is abandoned.

## Test plan
- Zero-wait read: `ibus_address` = 32'h8000_0010, slave returns 32'h2402_0005. Required: `haddr` = 32'h0000_0010, NONSEQ for exactly one cycle, stall high for 3 cycles, `ibus_rddata` = 32'h2402_0005 in the DONE cycle.
- Wait states: slave holds `hready` = 0 for 2 cycles in the data phase. Required: stall extends to 5 cycles and `htrans` stays IDLE after the address phase.
- Byte write: address 32'hA000_0103, BE = 4'b1000, `wrdata` = 32'hAB00_0000. Required: `haddr` = 32'h0000_0103, `hsize` = 3'b000, `hwrite` = 1, `hwdata` = 32'hAB00_0000.
- Back-to-back reads at 32'h8000_0000 and 32'h8000_0004. Required: two separate NONSEQ beats, each result delivered in its own DONE cycle, no overlap.
- Two-cycle ERROR on a read. Required: `ibus_error` = 1 and `ibus_rddata` = 0 in DONE, then `ibus_error` = 0 on the following cycle.
- `rst_n` low during DATA, and separately `ibus_read` dropped during ADDR. Required: reset gives state IDLE and `htrans` = IDLE on the next edge; the dropped request completes on AHB with no DONE cycle and `ibus_rddata` unchanged.

Source files
------------

// File: rtl/ibus_ahb_master.sv
// Bridges the CPU instruction bus onto AHB-Lite: one single transfer per ibus
// request, with the CPU stalled until the data phase completes.
module ibus_ahb_master #(
    parameter logic [31:0] ADDR_MASK = 32'h1FFF_FFFF,
    parameter logic [3:0]  HPROT_VAL = 4'b0010
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ibus_address,
    input  logic        ibus_read,
    input  logic        ibus_write,
    input  logic [3:0]  ibus_byteenable,
    input  logic [31:0] ibus_wrdata,
    output logic [31:0] ibus_rddata,
    output logic        ibus_stall,
    output logic        ibus_error,
    output logic [31:0] AHB_haddr,
    output logic [1:0]  AHB_htrans,
    output logic        AHB_hwrite,
    output logic [2:0]  AHB_hsize,
    output logic [2:0]  AHB_hburst,
    output logic [3:0]  AHB_hprot,
    output logic [31:0] AHB_hwdata,
    input  logic [31:0] AHB_hrdata,
    input  logic        AHB_hready,
    input  logic        AHB_hresp,
    output logic [1:0]  o_dbg_state
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [31:0] r_haddr;
    logic [1:0]  r_htrans;
    logic        r_hwrite;
    logic [2:0]  r_hsize;
    logic [31:0] r_hwdata;
    logic [31:0] r_rddata;
    logic        r_error;
    logic        r_dropped;

    logic        w_req;
    logic        w_is_write;
    logic        w_keep;
    logic [2:0]  w_size;
    logic [1:0]  w_lo;
    logic [31:0] w_haddr_next;

    assign w_req      = ibus_read | ibus_write;
    assign w_is_write = ~ibus_read & ibus_write;
    // A request that went away at any point during the beat gets no DONE cycle.
    assign w_keep     = w_req & ~r_dropped;

    // Byte-enable pattern selects transfer size and the low address bits.
    always_comb begin
        w_size = 3'b010;
        w_lo   = 2'b00;
        if (w_is_write) begin
            case (ibus_byteenable)
                4'b0011: begin w_size = 3'b001; w_lo = 2'b00; end
                4'b1100: begin w_size = 3'b001; w_lo = 2'b10; end
                4'b0001: begin w_size = 3'b000; w_lo = 2'b00; end
                4'b0010: begin w_size = 3'b000; w_lo = 2'b01; end
                4'b0100: begin w_size = 3'b000; w_lo = 2'b10; end
                4'b1000: begin w_size = 3'b000; w_lo = 2'b11; end
                default: begin w_size = 3'b010; w_lo = 2'b00; end
            endcase
        end
    end

    assign w_haddr_next = (ibus_address & ADDR_MASK & 32'hFFFF_FFFC) | {30'b0, w_lo};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        ibus_stall   = w_req;
        case (r_state)
            ST_IDLE: begin
                if (w_req) w_next_state = ST_ADDR;
            end
            ST_ADDR: begin
                if (AHB_hready) w_next_state = ST_DATA;
            end
            ST_DATA: begin
                if (AHB_hready) w_next_state = w_keep ? ST_DONE : ST_IDLE;
            end
            ST_DONE: begin
                ibus_stall   = 1'b0;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_haddr   <= 32'h0;
            r_htrans  <= HTRANS_IDLE;
            r_hwrite  <= 1'b0;
            r_hsize   <= 3'b010;
            r_hwdata  <= 32'h0;
            r_rddata  <= 32'h0;
            r_error   <= 1'b0;
            r_dropped <= 1'b0;
        end else begin
            r_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_dropped <= 1'b0;
                    if (w_req) begin
                        r_haddr  <= w_haddr_next;
                        r_htrans <= HTRANS_NONSEQ;
                        r_hwrite <= w_is_write;
                        r_hsize  <= w_size;
                        r_hwdata <= ibus_wrdata;
                    end
                end
                ST_ADDR: begin
                    if (!w_req) r_dropped <= 1'b1;
                    if (AHB_hready) r_htrans <= HTRANS_IDLE;
                end
                ST_DATA: begin
                    if (AHB_hready) begin
                        if (w_keep) begin
                            r_error <= AHB_hresp;
                            // An errored read returns zero rather than bus garbage.
                            if (!r_hwrite) r_rddata <= AHB_hresp ? 32'h0 : AHB_hrdata;
                        end
                    end else if (!w_req) begin
                        r_dropped <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ibus_rddata = r_rddata;
    assign ibus_error  = r_error;
    assign AHB_haddr   = r_haddr;
    assign AHB_htrans  = r_htrans;
    assign AHB_hwrite  = r_hwrite;
    assign AHB_hsize   = r_hsize;
    assign AHB_hburst  = 3'b000;
    assign AHB_hprot   = HPROT_VAL;
    assign AHB_hwdata  = r_hwdata;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ibus_ahb_master.sv
// Bench for ibus_ahb_master: a planned AHB slave, a CPU-side driver and a
// transaction-level model of stall, error and read-data behaviour.
module tb_ibus_ahb_master;

    localparam logic [31:0] MASK  = 32'h1FFF_FFFF;
    localparam logic [3:0]  HPROT = 4'b0010;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ibus_address = '0;
    logic        ibus_read = 1'b0;
    logic        ibus_write = 1'b0;
    logic [3:0]  ibus_byteenable = '0;
    logic [31:0] ibus_wrdata = '0;
    logic [31:0] ibus_rddata;
    logic        ibus_stall;
    logic        ibus_error;
    logic [31:0] AHB_haddr;
    logic [1:0]  AHB_htrans;
    logic        AHB_hwrite;
    logic [2:0]  AHB_hsize;
    logic [2:0]  AHB_hburst;
    logic [3:0]  AHB_hprot;
    logic [31:0] AHB_hwdata;
    logic [31:0] AHB_hrdata = '0;
    logic        AHB_hready = 1'b1;
    logic        AHB_hresp = 1'b0;
    logic [1:0]  o_dbg_state;

    ibus_ahb_master #(.ADDR_MASK(MASK), .HPROT_VAL(HPROT)) dut (
        .clk(clk), .rst_n(rst_n),
        .ibus_address(ibus_address), .ibus_read(ibus_read), .ibus_write(ibus_write),
        .ibus_byteenable(ibus_byteenable), .ibus_wrdata(ibus_wrdata),
        .ibus_rddata(ibus_rddata), .ibus_stall(ibus_stall), .ibus_error(ibus_error),
        .AHB_haddr(AHB_haddr), .AHB_htrans(AHB_htrans), .AHB_hwrite(AHB_hwrite),
        .AHB_hsize(AHB_hsize), .AHB_hburst(AHB_hburst), .AHB_hprot(AHB_hprot),
        .AHB_hwdata(AHB_hwdata), .AHB_hrdata(AHB_hrdata), .AHB_hready(AHB_hready),
        .AHB_hresp(AHB_hresp), .o_dbg_state(o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        logic        rd;
        logic [31:0] haddr;
        logic [2:0]  hsize;
        logic [31:0] wdata;
        int          wa;
        int          wd;
        logic        resp;
        logic [31:0] rdata;
    } plan_t;

    plan_t       plan_q[$];
    logic [31:0] exp_q[$];
    int          plans_issued = 0;
    int          plans_done = 0;
    int          beats = 0;

    logic        chk_en = 1'b0;
    logic        m_req = 1'b0;
    logic        m_err = 1'b0;
    logic        m_rd_upd = 1'b0;
    int          m_done_cyc = -1;
    logic [31:0] m_rddata = '0;

    function automatic logic [2:0] exp_size(input logic rd, input logic [3:0] be);
        if (rd) return 3'b010;
        case (be)
            4'b0011, 4'b1100:                   return 3'b001;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: return 3'b000;
            default:                            return 3'b010;
        endcase
    endfunction

    function automatic logic [31:0] exp_haddr(input logic rd, input logic [31:0] addr, input logic [3:0] be);
        logic [31:0] a;
        a = addr & MASK;
        a[1:0] = 2'b00;
        if (!rd) begin
            case (be)
                4'b1100: a[1:0] = 2'b10;
                4'b0010: a[1:0] = 2'b01;
                4'b0100: a[1:0] = 2'b10;
                4'b1000: a[1:0] = 2'b11;
                default: a[1:0] = 2'b00;
            endcase
        end
        return a;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            if (m_req && m_rd_upd && cyc == m_done_cyc) begin
                if (exp_q.size() > 0) m_rddata = exp_q.pop_front();
                else check("exp_q_underflow", 32'd0, 32'd1);
            end
            check("stall", ibus_stall, (m_req && cyc != m_done_cyc));
            check("error", ibus_error, (m_req && cyc == m_done_cyc && m_err));
            check("rddata", ibus_rddata, m_rddata);
            check("hburst", AHB_hburst, 3'b000);
            check("hprot", AHB_hprot, HPROT);
            if (AHB_htrans == 2'b10 && AHB_hready) beats++;
        end
    end

    // ---------------- AHB slave ----------------
    initial begin
        plan_t p;
        forever begin
            @(posedge clk); #1;
            if (AHB_htrans == 2'b10) begin
                if (plan_q.size() == 0) begin
                    check("unplanned_nonseq", 32'd1, 32'd0);
                end else begin
                    p = plan_q.pop_front();
                    check("haddr", AHB_haddr, p.haddr);
                    check("hsize", AHB_hsize, p.hsize);
                    check("hwrite", AHB_hwrite, !p.rd);
                    for (int i = 0; i < p.wa; i++) begin
                        AHB_hready = 1'b0;
                        @(posedge clk); #1;
                        check("htrans_addr_wait", AHB_htrans, 2'b10);
                    end
                    AHB_hready = 1'b1;
                    @(posedge clk); #1;
                    check("htrans_data", AHB_htrans, 2'b00);
                    if (!p.rd) check("hwdata", AHB_hwdata, p.wdata);
                    for (int i = 0; i < p.wd; i++) begin
                        AHB_hready = 1'b0;
                        AHB_hresp  = p.resp && (i == p.wd - 1);
                        @(posedge clk); #1;
                        check("htrans_data_wait", AHB_htrans, 2'b00);
                    end
                    AHB_hready = 1'b1;
                    AHB_hresp  = p.resp;
                    AHB_hrdata = p.rdata;
                    @(posedge clk); #1;
                    AHB_hresp  = 1'b0;
                    AHB_hrdata = $urandom;
                    plans_done++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_plan(input logic rd, input logic [31:0] addr, input logic [3:0] be,
                             input logic [31:0] wdata, input int wa, input int wd,
                             input logic resp, input logic [31:0] rdata);
        plan_t p;
        p.rd = rd; p.haddr = exp_haddr(rd, addr, be); p.hsize = exp_size(rd, be);
        p.wdata = wdata; p.wa = wa; p.wd = wd; p.resp = resp; p.rdata = rdata;
        plan_q.push_back(p);
        plans_issued++;
    endtask

    task automatic do_txn(input logic rd, input logic also_wr, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata, input int wa,
                          input int wd, input logic resp, input logic [31:0] rdata,
                          output int stall_cnt, output logic err_seen, output logic [31:0] rd_seen);
        push_plan(rd, addr, be, wdata, wa, wd, resp, rdata);
        ibus_read = rd; ibus_write = rd ? also_wr : 1'b1;
        ibus_address = addr; ibus_byteenable = be; ibus_wrdata = wdata;
        m_req = 1'b1; m_err = resp; m_rd_upd = rd;
        m_done_cyc = cyc + 3 + wa + wd;
        if (rd) exp_q.push_back(resp ? 32'h0 : rdata);
        stall_cnt = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!ibus_stall) break;
            stall_cnt++;
        end
        err_seen = ibus_error;
        rd_seen  = ibus_rddata;
        check("latency", stall_cnt, 3 + wa + wd);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        ibus_read = 1'b0; ibus_write = 1'b0; m_req = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_slave();
        for (int k = 0; k < 60; k++) begin
            if (plans_done == plans_issued) break;
            @(posedge clk); #1;
        end
        check("slave_drained", plans_done, plans_issued);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          cnt;
        logic        e;
        logic [31:0] r;
        logic [31:0] prev;
        int          done_seen;
        int          beats0;

        repeat (2) @(posedge clk); #1;
        chk_en = 1'b1;
        check("rst_htrans", AHB_htrans, 2'b00);
        check("rst_haddr", AHB_haddr, 32'h0);
        check("rst_hwrite", AHB_hwrite, 1'b0);
        check("rst_hsize", AHB_hsize, 3'b010);
        check("rst_hwdata", AHB_hwdata, 32'h0);
        check("rst_rddata", ibus_rddata, 32'h0);
        check("rst_error", ibus_error, 1'b0);
        check("rst_state", o_dbg_state, 2'd0);
        ibus_read = 1'b1; m_req = 1'b1;
        @(posedge clk); #1;
        check("rst_stall_follows_req", ibus_stall, 1'b1);
        check("rst_state_with_req", o_dbg_state, 2'd0);
        ibus_read = 1'b0; m_req = 1'b0; rst_n = 1'b1;
        idle(2);

        // Zero-wait read
        check("model_haddr_read", exp_haddr(1'b1, 32'h8000_0010, 4'hF), 32'h0000_0010);
        do_txn(1'b1, 1'b0, 32'h8000_0010, 4'hF, 32'h0, 0, 0, 1'b0, 32'h2402_0005, cnt, e, r);
        check("zw_stall_cycles", cnt, 3);
        check("zw_rddata", r, 32'h2402_0005);
        idle(1);

        // Two data-phase wait states
        do_txn(1'b1, 1'b0, 32'h8000_0020, 4'hF, 32'h0, 0, 2, 1'b0, 32'h1234_5678, cnt, e, r);
        check("ws_stall_cycles", cnt, 5);
        check("ws_rddata", r, 32'h1234_5678);
        idle(1);

        // Byte write in the top lane
        check("model_haddr_byte", exp_haddr(1'b0, 32'hA000_0103, 4'b1000), 32'h0000_0103);
        check("model_hsize_byte", exp_size(1'b0, 4'b1000), 3'b000);
        do_txn(1'b0, 1'b0, 32'hA000_0103, 4'b1000, 32'hAB00_0000, 0, 0, 1'b0, 32'h0, cnt, e, r);
        check("bw_stall_cycles", cnt, 3);
        check("bw_rddata_kept", r, 32'h1234_5678);
        idle(1);

        // Back-to-back reads
        beats0 = beats;
        do_txn(1'b1, 1'b0, 32'h8000_0000, 4'hF, 32'h0, 0, 0, 1'b0, 32'hCAFE_0001, cnt, e, r);
        check("b2b_first", r, 32'hCAFE_0001);
        do_txn(1'b1, 1'b0, 32'h8000_0004, 4'hF, 32'h0, 0, 0, 1'b0, 32'hCAFE_0002, cnt, e, r);
        check("b2b_second", r, 32'hCAFE_0002);
        check("b2b_beats", beats - beats0, 2);

        // Two-cycle ERROR on a read
        do_txn(1'b1, 1'b0, 32'h8000_0040, 4'hF, 32'h0, 0, 1, 1'b1, 32'hDEAD_BEEF, cnt, e, r);
        check("err_flag", e, 1'b1);
        check("err_rddata", r, 32'h0);
        check("err_clears", ibus_error, 1'b0);
        idle(1);

        // Read dropped during ADDR: beat completes, no DONE, rddata untouched
        do_txn(1'b1, 1'b0, 32'h8000_0080, 4'hF, 32'h0, 0, 0, 1'b0, 32'h5555_AAAA, cnt, e, r);
        prev = ibus_rddata;
        push_plan(1'b1, 32'h8000_0090, 4'hF, 32'h0, 1, 1, 1'b0, 32'h7777_0000);
        ibus_read = 1'b1; ibus_address = 32'h8000_0090;
        m_req = 1'b1; m_rd_upd = 1'b0; m_err = 1'b0; m_done_cyc = cyc + 5;
        @(posedge clk); #1;
        ibus_read = 1'b0; m_req = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (o_dbg_state == 2'd3) done_seen++;
            if (plans_done == plans_issued) break;
        end
        @(negedge clk);
        if (o_dbg_state == 2'd3) done_seen++;
        check("drop_no_done", done_seen, 0);
        check("drop_state_idle", o_dbg_state, 2'd0);
        check("drop_rddata", ibus_rddata, prev);
        @(posedge clk); #1;
        wait_slave();

        // Reset asserted during the data phase
        push_plan(1'b1, 32'h8000_00A0, 4'hF, 32'h0, 0, 3, 1'b0, 32'h9999_0000);
        ibus_read = 1'b1; ibus_address = 32'h8000_00A0;
        m_req = 1'b1; m_rd_upd = 1'b0; m_err = 1'b0; m_done_cyc = cyc + 6;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_mid_in_data", o_dbg_state, 2'd2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        m_rddata = 32'h0;
        check("rst_mid_state", o_dbg_state, 2'd0);
        check("rst_mid_htrans", AHB_htrans, 2'b00);
        check("rst_mid_rddata", ibus_rddata, 32'h0);
        ibus_read = 1'b0; m_req = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        wait_slave();
        idle(1);

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            logic        rd;
            int          wa;
            int          wd;
            logic        resp;
            rd   = ($urandom_range(0, 1) == 1);
            wa   = $urandom_range(0, 2);
            wd   = $urandom_range(0, 3);
            resp = ($urandom_range(0, 5) == 0);
            if (resp && wd == 0) wd = 1;
            do_txn(rd, ($urandom_range(0, 3) == 0), $urandom, 4'($urandom_range(0, 15)),
                   $urandom, wa, wd, resp, $urandom, cnt, e, r);
            check("rnd_error", e, resp);
            if (rd) check("rnd_rddata", r, m_rddata);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
        end
        idle(2);
        wait_slave();
        check("beat_count", beats, plans_issued);
        check("exp_q_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete (checks %0d)", n_checks);
        $fatal(1);
    end

endmodule
